// File: rtl/sample_dispatch_ctrl.sv
// Byte-stream sample assembler and dispatcher for the spike-detection unit array.
// Optional WAIT_LSB resync timeout is compiled in with `define DISPATCH_TIMEOUT_EN.
module sample_dispatch_ctrl #(
    parameter int NUM_UNITS      = 2,
    parameter int DATA_WIDTH     = 16,
    parameter int SEL_WIDTH      = 2,
    parameter int PROCESS_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_in,
    input  logic [SEL_WIDTH-1:0]   unit_sel,
    output logic [DATA_WIDTH-1:0]  unit_sample,
    output logic [NUM_UNITS-1:0]   unit_valid,
    input  logic [NUM_UNITS-1:0]   unit_spike,
    input  logic [2*NUM_UNITS-1:0] unit_event,
    output logic                   spike_out,
    output logic [1:0]             event_out,
    output logic                   busy,
    output logic                   sel_err,
    output logic                   overrun
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WAIT_LSB = 3'd1;
    localparam logic [2:0] S_DISPATCH = 3'd2;
    localparam logic [2:0] S_PROCESS  = 3'd3;
    localparam logic [2:0] S_CAPTURE  = 3'd4;

    localparam int CNT_W = (PROCESS_CYCLES > 1) ? $clog2(PROCESS_CYCLES) : 1;

    if (NUM_UNITS < 1 || NUM_UNITS > 4 || PROCESS_CYCLES < 1 || TIMEOUT_CYCLES < 1
        || DATA_WIDTH != 16) begin : g_param_check
        $error("sample_dispatch_ctrl: parameter out of range");
    end

    logic [2:0]            r_state;
    logic                  r_bv_q;
    logic [7:0]            r_msb_q;
    logic [SEL_WIDTH-1:0]  r_sel_q;
    logic [DATA_WIDTH-1:0] r_sample;
    logic                  r_busy;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_sel_err;
    logic                  r_overrun;

    logic                   w_accept;
    logic                   w_busy_state;
    logic                   w_sel_ok;
    logic [NUM_UNITS-1:0]   w_hit;
    logic [NUM_UNITS-1:0]   w_res_spike;
    logic [2*NUM_UNITS-1:0] w_res_event;

`ifdef DISPATCH_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_to_cnt;
`endif

    // Rising-edge detect: a strobe held for several cycles is one byte.
    assign w_accept     = byte_valid & ~r_bv_q & ena;
    assign w_busy_state = (r_state == S_DISPATCH) | (r_state == S_PROCESS) | (r_state == S_CAPTURE);
    assign w_sel_ok     = |w_hit;

    assign unit_sample = r_sample;
    assign unit_valid  = (ena && r_state == S_DISPATCH) ? w_hit : '0;
    assign busy        = r_busy;
    assign sel_err     = r_sel_err;
    assign overrun     = r_overrun;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_bv_q    <= 1'b0;
            r_msb_q   <= '0;
            r_sel_q   <= '0;
            r_sample  <= '0;
            r_busy    <= 1'b0;
            r_cnt     <= '0;
            r_sel_err <= 1'b0;
            r_overrun <= 1'b0;
`ifdef DISPATCH_TIMEOUT_EN
            r_to_cnt  <= '0;
`endif
        end else begin
            r_bv_q <= byte_valid;
            if (ena) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_msb_q <= byte_in;
                            r_sel_q <= unit_sel;
                            r_state <= S_WAIT_LSB;
`ifdef DISPATCH_TIMEOUT_EN
                            r_to_cnt <= '0;
`endif
                        end
                    end
                    S_WAIT_LSB: begin
                        if (w_accept) begin
                            r_sample <= DATA_WIDTH'({r_msb_q, byte_in});
                            r_busy   <= 1'b1;
                            r_state  <= S_DISPATCH;
`ifdef DISPATCH_TIMEOUT_EN
                        end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                            // Lost LSB: drop the half sample to regain byte alignment.
                            r_sel_err <= 1'b1;
                            r_state   <= S_IDLE;
                        end else begin
                            r_to_cnt <= r_to_cnt + 1'b1;
`endif
                        end
                    end
                    S_DISPATCH: begin
                        if (!w_sel_ok) r_sel_err <= 1'b1;
                        r_cnt   <= CNT_W'(PROCESS_CYCLES - 1);
                        r_state <= (PROCESS_CYCLES == 1) ? S_CAPTURE : S_PROCESS;
                    end
                    S_PROCESS: begin
                        // CAPTURE occupies the last cycle of the processing window.
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CNT_W'(1)) r_state <= S_CAPTURE;
                    end
                    S_CAPTURE: begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
                if (w_accept && w_busy_state) r_overrun <= 1'b1;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_res
        logic       r_spike;
        logic [1:0] r_event;

        assign w_hit[gi]              = (r_sel_q == SEL_WIDTH'(gi));
        assign w_res_spike[gi]        = r_spike;
        assign w_res_event[2*gi +: 2] = r_event;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_spike <= 1'b0;
                r_event <= 2'b00;
            end else if (ena && r_state == S_CAPTURE && w_hit[gi]) begin
                r_spike <= unit_spike[gi];
                r_event <= unit_event[2*gi +: 2];
            end
        end
    end

    // Live selector picks the result; out-of-range selectors read as zero.
    always_comb begin
        spike_out = 1'b0;
        event_out = 2'b00;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (unit_sel == SEL_WIDTH'(i)) begin
                spike_out = w_res_spike[i];
                event_out = w_res_event[2*i +: 2];
            end
        end
    end

endmodule

// File: doc/sample_dispatch_ctrl.md
Name: sample_dispatch_ctrl

Overview:
Sequencer between the byte-wide host stream and the array of spike-detection units inside tt_um_top_layer. It assembles 16-bit samples from two byte strobes (MSB first) and dispatches each sample to the unit chosen by the host selector with a one-cycle valid pulse. It then waits a fixed processing window, captures that unit's spike/event result into a per-unit result register, and muxes the selected unit's result onto the output pins.

Parameters:
NUM_UNITS, 2, number of detection units served (1..4)
DATA_WIDTH, 16, sample width; fixed at 2 bytes
SEL_WIDTH, 2, width of unit selector
PROCESS_CYCLES, 2, cycles between dispatch and result capture (>=1)
TIMEOUT_CYCLES, 255, idle cycles in WAIT_LSB before resync (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
ena  in  1  global enable; low freezes FSM and counters
byte_valid  in  1  host byte strobe (ui_in[2])
byte_in  in  8  host data byte (uio_in)
unit_sel  in  SEL_WIDTH  host unit selector (ui_in[1:0])
unit_sample  out  DATA_WIDTH  assembled sample, shared by all units
unit_valid  out  NUM_UNITS  one-hot dispatch pulse
unit_spike  in  NUM_UNITS  per-unit spike flag from units
unit_event  in  2*NUM_UNITS  per-unit 2-bit event code, unit i at [2i+1:2i]
spike_out  out  1  captured spike of unit_sel (uo_out[0])
event_out  out  2  captured event of unit_sel (uo_out[2:1])
busy  out  1  high from LSB accept through capture
sel_err  out  1  sticky: sample addressed to unit_sel >= NUM_UNITS
overrun  out  1  sticky: byte strobe dropped while busy

Behaviour:
- Reset: clk and rst_n only; synchronous, active-low. Clears all registers; every output is 0, FSM goes to IDLE, result registers are 0, stickies are 0.
- Strobe detect: accept = byte_valid & ~byte_valid_q & ena. A strobe held high for N cycles counts once. byte_valid_q updates even when ena is low.
- FSM states: IDLE, WAIT_LSB, DISPATCH, PROCESS, CAPTURE.
- IDLE, accept: msb_q <= byte_in; sel_q <= unit_sel; go to WAIT_LSB.
- WAIT_LSB, accept (edge E0): unit_sample <= {msb_q, byte_in}; busy <= 1; go to DISPATCH.
- DISPATCH, one cycle: unit_valid[sel_q] = 1 during the cycle after E0, only if sel_q < NUM_UNITS. Otherwise unit_valid stays 0 and sel_err <= 1. Counter loads PROCESS_CYCLES-1; go to PROCESS.
- PROCESS: decrement the counter; at 0 go to CAPTURE.
- CAPTURE, edge E0+1+PROCESS_CYCLES: if sel_q is valid, res_spike[sel_q] <= unit_spike[sel_q] and res_event[sel_q] <= unit_event slice. busy <= 0; go to IDLE.
- Latency: LSB accept to result visible = 1+PROCESS_CYCLES edges (3 at default).
- unit_sample holds its value until the next LSB accept.
- Output mux: combinational from the result registers using the live unit_sel. An out-of-range unit_sel gives spike_out=0, event_out=00.
- Accept during DISPATCH/PROCESS/CAPTURE: byte dropped; overrun <= 1; FSM unaffected.
- unit_sel changing between MSB and LSB: ignored; sel_q governs dispatch.
- ena low: FSM, counter and stickies hold; no accept. unit_valid is forced 0 and the pulse resumes when ena returns.
- Reset mid-operation: immediate return to IDLE; a partial sample is discarded.
- Stickies clear only on reset.

Optional Feature:
Macro DISPATCH_TIMEOUT_EN.
- Defined: an idle counter runs in WAIT_LSB and resets on each accept. After TIMEOUT_CYCLES cycles with no accept, the FSM returns to IDLE, msb_q is discarded and sel_err <= 1. This resyncs byte alignment.
- Undefined: WAIT_LSB waits indefinitely; no counter is synthesized.

Test Plan:
1. Reset held 8 cycles, then released -> all outputs 0, busy=0, stickies 0.
2. unit_sel=0; strobes 0x12 then 0x34 (one cycle each); unit0 drives spike=1, event=10 -> unit_sample=0x1234; unit_valid=01 for exactly one cycle after E0; spike_out=1, event_out=10 after edge E0+3; switching unit_sel=1 gives spike_out=0, event_out=00.
3. byte_valid held high 3 cycles with 0xAB, then a single strobe 0xCD, unit_sel=1 -> one sample 0xABCD, unit_valid=10 once.
4. Strobe 0xFF during PROCESS -> overrun=1; next pair 0x00,0x05 -> unit_sample=0x0005 with correct dispatch.
5. unit_sel=3, NUM_UNITS=2, pair 0x11,0x22 -> unit_valid stays 00, sel_err=1, busy still pulses for 1+PROCESS_CYCLES cycles, result registers unchanged.
6. With DISPATCH_TIMEOUT_EN: MSB 0x77, then 255 idle cycles -> FSM back in IDLE, sel_err=1; pair 0xAB,0xCD -> 0xABCD. Without the macro, the same idle gap followed by 0xAB -> sample 0x77AB.
